// File: rtl/ami_app_rr_scheduler_pkg.sv
// Shared sizing for the AMI round-robin scheduler: default app count, read credit cap,
// read-order FIFO depth, and the id-width helper used by the top and the FIFO.
package ami_app_rr_scheduler_pkg;

   localparam int F1_NUM_APPS                   = 8;
   localparam int F1_AMI_SCHED_MAX_RD_OUTST     = 8;
   localparam int F1_AMI_SCHED_ORDER_FIFO_Depth = 32;

   // Width of an index over n items; never zero, so a single-app build still elaborates.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ami_app_rr_scheduler_order_fifo.sv
// In-order record of which app issued each outstanding read. Full and empty are registered,
// so a pop in the same cycle never makes room for a push.
module ami_sched_order_fifo
   import ami_app_rr_scheduler_pkg::*;
#(
   parameter int W     = 3,
   parameter int DEPTH = F1_AMI_SCHED_ORDER_FIFO_Depth
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int PW = id_width(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + (PW+1)'(1);
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (PW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage carries no reset; an entry is only read while empty_q is low.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/ami_app_rr_scheduler.sv
// Round-robin sharing of one AMI channel among NUM_APPS apps, with per-app read credits,
// in-order response steering through the order FIFO, and per-app quiescence reporting.
module ami_app_rr_scheduler
   import ami_app_rr_scheduler_pkg::*;
#(
   parameter int  NUM_APPS     = F1_NUM_APPS,
   parameter int  ADDR_W       = 64,
   parameter int  DATA_W       = 512,
   parameter int  MAX_RD_OUTST = F1_AMI_SCHED_MAX_RD_OUTST,
   parameter int  ORDER_DEPTH  = F1_AMI_SCHED_ORDER_FIFO_Depth,
   localparam int AW           = id_width(NUM_APPS)
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_APPS-1:0]        app_enable,
   input  logic [NUM_APPS-1:0]        req_valid,
   input  logic [NUM_APPS-1:0]        req_is_write,
   input  logic [NUM_APPS*ADDR_W-1:0] req_addr,
   input  logic [NUM_APPS*DATA_W-1:0] req_data,
   output logic [NUM_APPS-1:0]        req_ready,
   output logic                       mem_req_valid,
   output logic                       mem_req_is_write,
   output logic [ADDR_W-1:0]          mem_req_addr,
   output logic [DATA_W-1:0]          mem_req_data,
   output logic [AW-1:0]              mem_req_app,
   input  logic                       mem_req_ready,
   input  logic                       mem_rsp_valid,
   input  logic [DATA_W-1:0]          mem_rsp_data,
   output logic                       mem_rsp_ready,
   output logic [NUM_APPS-1:0]        app_rsp_valid,
   output logic [DATA_W-1:0]          app_rsp_data,
   input  logic [NUM_APPS-1:0]        app_rsp_ready,
   output logic [NUM_APPS-1:0]        app_quiesced,
   output logic                       err_orphan_rsp
);

   localparam int CW = $clog2(MAX_RD_OUTST + 1);

   // Handshakes: a beat moves on a cycle where valid and ready are both high; the request
   // side holds mem_req_* stable while mem_req_valid is high and mem_req_ready is low.
   logic [AW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]       rd_cnt_q [NUM_APPS];
   logic [CW-1:0]       rd_cnt_d [NUM_APPS];
   logic                mem_req_valid_q, mem_req_is_write_q;
   logic [ADDR_W-1:0]   mem_req_addr_q;
   logic [DATA_W-1:0]   mem_req_data_q;
   logic [AW-1:0]       mem_req_app_q;
   logic [NUM_APPS-1:0] quiesced_q, quiesced_d;
   logic                err_q;

   logic [NUM_APPS-1:0] eligible;
   logic                can_issue, grant_found, grant, grant_rd;
   logic [AW-1:0]       grant_idx;
   logic [AW-1:0]       head;
   logic                fifo_full, fifo_empty, pop, orphan;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_APPS; i++) begin
         eligible[i] = req_valid[i] & app_enable[i] &
                       (req_is_write[i] | ((rd_cnt_q[i] < CW'(MAX_RD_OUTST)) & ~fifo_full));
      end
   end

   always_comb begin
      logic [AW:0] cand;
      cand        = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_APPS; k++) begin
         cand = {1'b0, rr_ptr_q} + (AW+1)'(k);
         if (cand >= (AW+1)'(NUM_APPS)) cand = cand - (AW+1)'(NUM_APPS);
         if (!grant_found && eligible[cand[AW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[AW-1:0];
         end
      end
   end

   assign can_issue = ~mem_req_valid_q | mem_req_ready;
   assign grant     = can_issue & grant_found & ~rst;
   assign grant_rd  = grant & ~req_is_write[grant_idx];
   assign req_ready = grant ? (NUM_APPS'(1) << grant_idx) : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (grant_idx == AW'(NUM_APPS - 1)) ? '0 : grant_idx + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q           <= '0;
         mem_req_valid_q    <= 1'b0;
         mem_req_is_write_q <= 1'b0;
         mem_req_addr_q     <= '0;
         mem_req_data_q     <= '0;
         mem_req_app_q      <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (can_issue) begin
            mem_req_valid_q <= grant;
            if (grant) begin
               mem_req_is_write_q <= req_is_write[grant_idx];
               mem_req_addr_q     <= req_addr[grant_idx*ADDR_W +: ADDR_W];
               mem_req_data_q     <= req_data[grant_idx*DATA_W +: DATA_W];
               mem_req_app_q      <= grant_idx;
            end
         end
      end
   end

   ami_sched_order_fifo #(
      .W     (AW),
      .DEPTH (ORDER_DEPTH)
   ) u_order_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (grant_rd),
      .push_data_i (grant_idx),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // With no read in flight any response is unexpected: accept and drop it.
   always_comb begin
      app_rsp_valid = '0;
      mem_rsp_ready = 1'b1;
      if (!fifo_empty) begin
         app_rsp_valid[head] = mem_rsp_valid;
         mem_rsp_ready       = app_rsp_ready[head];
      end
   end

   assign orphan       = mem_rsp_valid & fifo_empty;
   assign pop          = mem_rsp_valid & mem_rsp_ready & ~fifo_empty & ~rst;
   assign app_rsp_data = mem_rsp_data;

   always_comb begin
      for (int i = 0; i < NUM_APPS; i++) begin
         rd_cnt_d[i] = rd_cnt_q[i];
         if ((grant_rd && grant_idx == AW'(i)) && !(pop && head == AW'(i))) begin
            rd_cnt_d[i] = rd_cnt_q[i] + CW'(1);
         end else if ((pop && head == AW'(i)) && !(grant_rd && grant_idx == AW'(i))) begin
            rd_cnt_d[i] = rd_cnt_q[i] - CW'(1);
         end
         quiesced_d[i] = ~app_enable[i] & (rd_cnt_q[i] == '0) &
                         ~(mem_req_valid_q & (mem_req_app_q == AW'(i)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_APPS; i++) rd_cnt_q[i] <= '0;
         quiesced_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_APPS; i++) rd_cnt_q[i] <= rd_cnt_d[i];
         quiesced_q <= quiesced_d;
         if (orphan) err_q <= 1'b1;
      end
   end

   assign mem_req_valid    = mem_req_valid_q;
   assign mem_req_is_write = mem_req_is_write_q;
   assign mem_req_addr     = mem_req_addr_q;
   assign mem_req_data     = mem_req_data_q;
   assign mem_req_app      = mem_req_app_q;
   assign app_quiesced     = quiesced_q;
   assign err_orphan_rsp   = err_q;

endmodule

// File: tb/tb_ami_app_rr_scheduler.sv
// Directed bench for ami_app_rr_scheduler: a per-cycle vector table for arbitration and
// steering, then hand sequences for credits, stall, quiescence, orphans and mid-run reset.
module tb_ami_app_rr_scheduler;

   localparam int NA = 8;
   localparam int AD = 64;
   localparam int DW = 512;

   logic             clk = 1'b0;
   logic             rst;
   logic [NA-1:0]    app_enable, req_valid, req_is_write, req_ready;
   logic [NA*AD-1:0] req_addr;
   logic [NA*DW-1:0] req_data;
   logic             mem_req_valid, mem_req_is_write, mem_req_ready;
   logic [AD-1:0]    mem_req_addr;
   logic [DW-1:0]    mem_req_data;
   logic [2:0]       mem_req_app;
   logic             mem_rsp_valid, mem_rsp_ready;
   logic [DW-1:0]    mem_rsp_data;
   logic [NA-1:0]    app_rsp_valid, app_rsp_ready, app_quiesced;
   logic [DW-1:0]    app_rsp_data;
   logic             err_orphan_rsp;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ami_app_rr_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .app_enable       (app_enable),
      .req_valid        (req_valid),
      .req_is_write     (req_is_write),
      .req_addr         (req_addr),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .mem_req_valid    (mem_req_valid),
      .mem_req_is_write (mem_req_is_write),
      .mem_req_addr     (mem_req_addr),
      .mem_req_data     (mem_req_data),
      .mem_req_app      (mem_req_app),
      .mem_req_ready    (mem_req_ready),
      .mem_rsp_valid    (mem_rsp_valid),
      .mem_rsp_data     (mem_rsp_data),
      .mem_rsp_ready    (mem_rsp_ready),
      .app_rsp_valid    (app_rsp_valid),
      .app_rsp_data     (app_rsp_data),
      .app_rsp_ready    (app_rsp_ready),
      .app_quiesced     (app_quiesced),
      .err_orphan_rsp   (err_orphan_rsp)
   );

   typedef struct {
      logic [7:0] en, rv, wr;
      logic       mrr, rspv;
      logic [7:0] ardy;
      logic [7:0] e_rr;
      logic       e_mv;
      logic [2:0] e_app;
      logic [7:0] e_arv;
      logic       e_mrsr;
   } vec_t;

   vec_t tbl [17];

   function automatic logic [AD-1:0] addr_of(input int i);
      return 64'h1000_0000 + 64'(i) * 64'h100;
   endfunction

   function automatic logic [DW-1:0] data_of(input int i);
      return {16{32'hA5A5_0000 + 32'(i)}};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      app_enable = 8'hFF; req_valid = '0; req_is_write = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; app_rsp_ready = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int grants;
      for (int i = 0; i < NA; i++) begin
         req_addr[i*AD +: AD] = addr_of(i);
         req_data[i*DW +: DW] = data_of(i);
      end
      mem_rsp_data = {16{32'hDEAD_BEEF}};

      //            en     rv     wr     mrr   rspv  ardy   e_rr   mv    app   e_arv  mrsr
      tbl[0]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 3'd0, 8'h00, 1'b1};
      tbl[1]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h02, 1'b1, 3'd0, 8'h00, 1'b1};
      tbl[2]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h04, 1'b1, 3'd1, 8'h00, 1'b1};
      tbl[3]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h08, 1'b1, 3'd2, 8'h00, 1'b1};
      tbl[4]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h10, 1'b1, 3'd3, 8'h00, 1'b1};
      tbl[5]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h20, 1'b1, 3'd4, 8'h00, 1'b1};
      tbl[6]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h40, 1'b1, 3'd5, 8'h00, 1'b1};
      tbl[7]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h80, 1'b1, 3'd6, 8'h00, 1'b1};
      tbl[8]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, 3'd7, 8'h00, 1'b1};
      tbl[9]  = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h02, 1'b1, 3'd0, 8'h01, 1'b1};
      tbl[10] = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h04, 1'b1, 3'd1, 8'h02, 1'b1};
      tbl[11] = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h08, 1'b1, 3'd2, 8'h04, 1'b0};
      tbl[12] = '{8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h10, 1'b1, 3'd3, 8'h04, 1'b1};
      tbl[13] = '{8'hFF, 8'h21, 8'h20, 1'b1, 1'b0, 8'hFF, 8'h20, 1'b1, 3'd4, 8'h00, 1'b1};
      tbl[14] = '{8'hDF, 8'h21, 8'h20, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b1, 3'd5, 8'h00, 1'b1};
      tbl[15] = '{8'hDF, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 3'd0, 8'h00, 1'b1};
      tbl[16] = '{8'hDF, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1};

      // Reset state
      do_reset();
      #1;
      chk("rst_mem_req_valid", DW'(mem_req_valid), DW'(0));
      chk("rst_req_ready", DW'(req_ready), DW'(0));
      chk("rst_quiesced", DW'(app_quiesced), DW'(0));
      chk("rst_err", DW'(err_orphan_rsp), DW'(0));
      chk("rst_addr", DW'(mem_req_addr), DW'(0));
      chk("rst_data", mem_req_data, DW'(0));
      chk("rst_app_rsp_valid", DW'(app_rsp_valid), DW'(0));

      // Vector table: one row per cycle
      for (int i = 0; i < 17; i++) begin
         app_enable = tbl[i].en; req_valid = tbl[i].rv; req_is_write = tbl[i].wr;
         mem_req_ready = tbl[i].mrr; mem_rsp_valid = tbl[i].rspv; app_rsp_ready = tbl[i].ardy;
         #1;
         chk($sformatf("v%0d_req_ready", i), DW'(req_ready), DW'(tbl[i].e_rr));
         chk($sformatf("v%0d_mem_valid", i), DW'(mem_req_valid), DW'(tbl[i].e_mv));
         if (tbl[i].e_mv) chk($sformatf("v%0d_mem_app", i), DW'(mem_req_app), DW'(tbl[i].e_app));
         chk($sformatf("v%0d_app_rsp_valid", i), DW'(app_rsp_valid), DW'(tbl[i].e_arv));
         chk($sformatf("v%0d_mem_rsp_ready", i), DW'(mem_rsp_ready), DW'(tbl[i].e_mrsr));
         step();
      end

      // App 3 alone: credit cap of 8, then one response frees one slot a cycle later
      do_reset();
      req_valid = 8'h08; mem_req_ready = 1'b1; app_rsp_ready = 8'hFF;
      grants = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req_ready[3]) grants++;
         step();
      end
      chk("cap_grants", DW'(grants), DW'(8));
      #1;
      chk("cap_blocked", DW'(req_ready), DW'(0));
      mem_rsp_valid = 1'b1; app_rsp_ready = 8'h08;
      #1;
      chk("cap_rsp_steer", DW'(app_rsp_valid), DW'(8'h08));
      chk("cap_rsp_data", app_rsp_data, mem_rsp_data);
      chk("cap_same_cycle_blocked", DW'(req_ready), DW'(0));
      step();
      mem_rsp_valid = 1'b0;
      #1;
      chk("cap_ninth_grant", DW'(req_ready), DW'(8'h08));
      req_valid = '0;
      step();

      // App 5 write stalled for 4 cycles
      do_reset();
      req_valid = 8'h20; req_is_write = 8'h20; mem_req_ready = 1'b0;
      #1;
      chk("stall_grant5", DW'(req_ready), DW'(8'h20));
      step();
      req_valid = 8'h41; req_is_write = 8'h00;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("stall_no_grant", DW'(req_ready), DW'(0));
         chk("stall_valid", DW'(mem_req_valid), DW'(1));
         chk("stall_app", DW'(mem_req_app), DW'(5));
         chk("stall_is_write", DW'(mem_req_is_write), DW'(1));
         chk("stall_addr", DW'(mem_req_addr), DW'(addr_of(5)));
         chk("stall_data", mem_req_data, data_of(5));
         step();
      end
      mem_req_ready = 1'b1;
      #1;
      chk("stall_rr_next", DW'(req_ready), DW'(8'h40));
      step();
      chk("stall_next_app", DW'(mem_req_app), DW'(6));
      chk("stall_next_addr", DW'(mem_req_addr), DW'(addr_of(6)));
      req_valid = '0;
      step();

      // App 2 quiesces with three reads in flight
      do_reset();
      req_valid = 8'h04; mem_req_ready = 1'b1; app_rsp_ready = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("q_grant2", DW'(req_ready), DW'(8'h04));
         step();
      end
      app_enable = 8'hFB;
      #1;
      chk("q_blocked", DW'(req_ready), DW'(0));
      step();
      chk("q_blocked2", DW'(req_ready), DW'(0));
      chk("q_not_yet", DW'(app_quiesced), DW'(0));
      mem_rsp_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("q_rsp_steer", DW'(app_rsp_valid), DW'(8'h04));
         step();
      end
      mem_rsp_valid = 1'b0;
      step();
      chk("q_quiesced", DW'(app_quiesced), DW'(8'h04));
      chk("q_still_blocked", DW'(req_ready), DW'(0));
      req_valid = '0; app_enable = 8'hFF;
      step();

      // Orphan response with nothing outstanding
      do_reset();
      mem_rsp_valid = 1'b1; app_rsp_ready = '0;
      #1;
      chk("orph_ready", DW'(mem_rsp_ready), DW'(1));
      chk("orph_no_valid", DW'(app_rsp_valid), DW'(0));
      chk("orph_err_pre", DW'(err_orphan_rsp), DW'(0));
      step();
      mem_rsp_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("orph_err_sticky", DW'(err_orphan_rsp), DW'(1));
         step();
      end
      do_reset();
      #1;
      chk("orph_err_cleared", DW'(err_orphan_rsp), DW'(0));

      // Reset with 5 reads outstanding and the output register loaded
      req_valid = 8'h02; mem_req_ready = 1'b1; app_rsp_ready = 8'hFF;
      for (int c = 0; c < 5; c++) step();
      req_valid = '0; mem_req_ready = 1'b0;
      #1;
      chk("mr_pre_valid", DW'(mem_req_valid), DW'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mr_valid", DW'(mem_req_valid), DW'(0));
      chk("mr_req_ready", DW'(req_ready), DW'(0));
      chk("mr_quiesced", DW'(app_quiesced), DW'(0));
      chk("mr_err", DW'(err_orphan_rsp), DW'(0));
      mem_rsp_valid = 1'b1;
      #1;
      chk("mr_orphan_ready", DW'(mem_rsp_ready), DW'(1));
      chk("mr_orphan_valid", DW'(app_rsp_valid), DW'(0));
      step();
      mem_rsp_valid = 1'b0;
      chk("mr_orphan_err", DW'(err_orphan_rsp), DW'(1));
      req_valid = 8'h02; mem_req_ready = 1'b1;
      grants = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (req_ready[1]) grants++;
         step();
      end
      chk("mr_credits_restored", DW'(grants), DW'(8));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ami_app_rr_scheduler.md
# ami_app_rr_scheduler

Round-robin scheduler that shares one AMI memory channel among `NUM_APPS` application ports. It enforces a per-app read-outstanding cap and keeps an in-order tag FIFO so read responses are steered back to the app that issued them. It also gates new grants per app for quiescence, and reports when each disabled app has drained. It sits between the per-app AMI request ports and one AMI2AXI4 channel, one instance per `F1_NUM_MEM_CHANNELS`.

## Interface
Parameters:
- `NUM_APPS`, default 8 (`F1_NUM_APPS`): number of requesters.
- `ADDR_W`, default 64: byte address width.
- `DATA_W`, default 512: request and response data width.
- `MAX_RD_OUTST`, default 8: maximum outstanding reads per app.
- `ORDER_DEPTH`, default 32, power of 2: depth of the read-order FIFO.

Ports (`AW=$clog2(NUM_APPS)`):
- `clk` in 1: single clock.
- `rst` in 1: **synchronous, active-high reset**.
- `app_enable` in NUM_APPS: per-app grant enable (0 = quiescing).
- `req_valid` in NUM_APPS: per-app request valid.
- `req_is_write` in NUM_APPS: 1 = write, 0 = read.
- `req_addr` in NUM_APPS*ADDR_W: packed, app i at `[i*ADDR_W +: ADDR_W]`.
- `req_data` in NUM_APPS*DATA_W: packed write data.
- `req_ready` out NUM_APPS: one-hot grant/accept.
- `mem_req_valid`, `mem_req_is_write` out 1.
- `mem_req_addr` out ADDR_W.
- `mem_req_data` out DATA_W.
- `mem_req_app` out AW: id of the issuing app.
- `mem_req_ready` in 1.
- `mem_rsp_valid` in 1, `mem_rsp_data` in DATA_W, `mem_rsp_ready` out 1: read responses, in order.
- `app_rsp_valid` out NUM_APPS.
- `app_rsp_data` out DATA_W: shared by all apps.
- `app_rsp_ready` in NUM_APPS.
- `app_quiesced` out NUM_APPS: registered.
- `err_orphan_rsp` out 1: sticky.

## Operation
Eligibility:
- App i is eligible when `req_valid[i] & app_enable[i]`, plus, for reads, `rd_cnt[i] < MAX_RD_OUTST` and the order FIFO not full.
- Writes ignore both the credit limit and the order FIFO.

Arbitration:
- Rotating-priority search starts at `rr_ptr`; the first eligible app wins.
- Arbitration happens only when the output register is empty or draining this cycle (`!mem_req_valid | mem_req_ready`).
- On a grant:
  - `req_ready[g]=1` for that cycle only.
  - The output register loads that app's request plus `mem_req_app=g`.
  - `rr_ptr` becomes `(g+1) mod NUM_APPS`.
  - For a read, also push `g` into the order FIFO and increment `rd_cnt[g]`.
- If nothing is eligible, no `req_ready` is asserted and `rr_ptr` is unchanged.

Response steering:
- Let h be the order-FIFO head.
- `app_rsp_valid[h] = mem_rsp_valid`; all other bits are 0.
- `mem_rsp_ready = app_rsp_ready[h]`.
- On the handshake, pop the FIFO and decrement `rd_cnt[h]`.
- Orphan response (`mem_rsp_valid` while the FIFO is empty): `mem_rsp_ready=1`, the beat is dropped, no `app_rsp_valid` is asserted, and `err_orphan_rsp` is set until `rst`.

Counter and quiescence rules:
- Same-cycle issue and return for one app leaves `rd_cnt` unchanged.
- `rd_cnt` never wraps: the credit check blocks at the cap, and a decrement at 0 is impossible by construction.
- Deasserting `app_enable[i]` blocks new grants to app i only. A request already in the output register still issues, and in-flight reads still return.
- `app_quiesced[i]` is registered as `~app_enable[i] & rd_cnt[i]==0 & ~(mem_req_valid & mem_req_app==i)`.

## Timing
- Grant to `mem_req_valid`: 1 cycle, because the output is registered.
- Throughput: 1 request/cycle while `mem_req_ready` stays high.
- `mem_req_*` holds stable while `mem_req_valid & !mem_req_ready`.
- The response path is combinational: 0-cycle valid/ready passthrough.
- Reset values:
  - `mem_req_valid=0`, `req_ready=0`, `rr_ptr=0`, all `rd_cnt=0`, FIFO empty.
  - `app_quiesced=0`, then valid from the first post-reset cycle.
  - `err_orphan_rsp=0`; data outputs 0.
- A reset mid-operation discards the pending output request and all order state. Responses that arrive after reset count as orphans.
- Order FIFO full: reads are ineligible that cycle. A same-cycle pop does not free the slot, so it is a registered full check.

## Structure
- Add `F1_AMI_SCHED_MAX_RD_OUTST` and `F1_AMI_SCHED_ORDER_FIFO_Depth` to `AOSF1Types` alongside the existing FIFO depth parameters. The top level passes them in.
- The arbiter, credit counters and quiescence logic are inline in the top module.
- One sub-module, `ami_sched_order_fifo`: a synchronous FIFO of width AW and depth `ORDER_DEPTH`, with registered full/empty.

## Test plan
- All 8 apps issue reads continuously with `mem_req_ready=1` → grants go 0,1,…,7,0 with exactly one per cycle, and responses return to the matching app in order.
- App 3 alone issues 10 reads while responses are withheld → 8 are accepted, `req_ready[3]` then stays 0; one response → the 9th is granted the next cycle.
- App 5 sends a write with `mem_req_ready=0` for 4 cycles → `mem_req_*` is stable, no other grant occurs, and `rr_ptr` is unchanged until acceptance.
- Drop `app_enable[2]` with 3 reads outstanding → no new grants to app 2; `app_quiesced[2]` rises 1 cycle after the 3rd response handshake.
- `mem_rsp_valid` with the FIFO empty → `mem_rsp_ready=1`, all `app_rsp_valid=0`, `err_orphan_rsp=1` and held until `rst`.
- Assert `rst` with 5 reads outstanding and the output register full → all outputs and counters reach their reset values the next cycle.
